// File: rtl/instruction_decode.sv
// MIPS decode stage: field decode, 32-entry register file with write-back bypass, and the ID/EX pipeline register.
// Optional load-use interlock is enabled by defining LOAD_USE_STALL_EN.
module instruction_decode #(
   parameter int DATA_W   = 32,
   parameter bit RF_CLEAR = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       FD_IR,
   input  logic              MW_RegWrite,
   input  logic [4:0]        MW_RD,
   input  logic [DATA_W-1:0] MW_data,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] DX_SWdata,
   output logic [4:0]        DX_RD,
   output logic [2:0]        ALUctr,
   output logic              DX_RegWrite,
   output logic              DX_MemRead,
   output logic              DX_MemWrite,
   output logic              stall
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;

   assign op    = FD_IR[31:26];
   assign rs    = FD_IR[25:21];
   assign rt    = FD_IR[20:16];
   assign rd    = FD_IR[15:11];
   assign funct = FD_IR[5:0];
   assign imm   = FD_IR[15:0];

   logic [DATA_W-1:0] rf [32];
   logic              rf_we;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] imm_ext;

   assign rf_we   = MW_RegWrite && (MW_RD != 5'd0);
   assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};

   // Register 0 is hard-wired to zero; a same-cycle write-back wins over the stored value.
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs != 5'd0) rs_val = (rf_we && MW_RD == rs) ? MW_data : rf[rs];
      if (rt != 5'd0) rt_val = (rf_we && MW_RD == rt) ? MW_data : rf[rt];
   end

   generate
      if (RF_CLEAR) begin : g_rf_clear
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < 32; i++) rf[i] <= '0;
            end else if (rf_we) begin
               rf[MW_RD] <= MW_data;
            end
         end
      end else begin : g_rf_keep
         always_ff @(posedge clk) begin
            if (!rst && rf_we) rf[MW_RD] <= MW_data;
         end
      end
   endgenerate

   logic       d_valid;
   logic       d_use_imm;
   logic [4:0] d_rd;
   logic [2:0] d_alu;
   logic       d_rw;
   logic       d_mr;
   logic       d_mw;

   always_comb begin
      d_valid   = 1'b0;
      d_use_imm = 1'b0;
      d_rd      = 5'd0;
      d_alu     = 3'd0;
      d_rw      = 1'b0;
      d_mr      = 1'b0;
      d_mw      = 1'b0;
      case (op)
         OP_RTYPE: begin
            d_rd = rd;
            d_rw = 1'b1;
            case (funct)
               FN_ADD:  begin d_valid = 1'b1; d_alu = 3'd0; end
               FN_SUB:  begin d_valid = 1'b1; d_alu = 3'd1; end
               FN_SLT:  begin d_valid = 1'b1; d_alu = 3'd2; end
               default: d_valid = 1'b0;
            endcase
         end
         OP_ADDI: begin
            d_valid   = 1'b1;
            d_use_imm = 1'b1;
            d_rd      = rt;
            d_rw      = 1'b1;
         end
         OP_LW: begin
            d_valid   = 1'b1;
            d_use_imm = 1'b1;
            d_rd      = rt;
            d_rw      = 1'b1;
            d_mr      = 1'b1;
         end
         OP_SW: begin
            d_valid   = 1'b1;
            d_use_imm = 1'b1;
            d_mw      = 1'b1;
         end
         default: d_valid = 1'b0;
      endcase
   end

`ifdef LOAD_USE_STALL_EN
   // rt is a true source only for R-type and sw; addi/lw overwrite rt instead.
   assign stall = DX_MemRead && (DX_RD != 5'd0) &&
                  ((DX_RD == rs) || (d_valid && (!d_use_imm || d_mw) && (DX_RD == rt)));
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         A           <= '0;
         B           <= '0;
         DX_SWdata   <= '0;
         DX_RD       <= 5'd0;
         ALUctr      <= 3'd0;
         DX_RegWrite <= 1'b0;
         DX_MemRead  <= 1'b0;
         DX_MemWrite <= 1'b0;
      end else if (!d_valid || stall) begin
         A           <= '0;
         B           <= '0;
         DX_SWdata   <= '0;
         DX_RD       <= 5'd0;
         ALUctr      <= 3'd0;
         DX_RegWrite <= 1'b0;
         DX_MemRead  <= 1'b0;
         DX_MemWrite <= 1'b0;
      end else begin
         A           <= rs_val;
         B           <= d_use_imm ? imm_ext : rt_val;
         DX_SWdata   <= rt_val;
         DX_RD       <= d_rd;
         ALUctr      <= d_alu;
         DX_RegWrite <= d_rw;
         DX_MemRead  <= d_mr;
         DX_MemWrite <= d_mw;
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: expected DX values are queued at issue and checked one cycle later.
module tb_instruction_decode;

   logic        clk;
   logic        rst;
   logic [31:0] FD_IR;
   logic        MW_RegWrite;
   logic [4:0]  MW_RD;
   logic [31:0] MW_data;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] DX_SWdata;
   logic [4:0]  DX_RD;
   logic [2:0]  ALUctr;
   logic        DX_RegWrite;
   logic        DX_MemRead;
   logic        DX_MemWrite;
   logic        stall;

   instruction_decode #(.DATA_W(32), .RF_CLEAR(1'b1)) dut (
      .clk(clk), .rst(rst), .FD_IR(FD_IR),
      .MW_RegWrite(MW_RegWrite), .MW_RD(MW_RD), .MW_data(MW_data),
      .A(A), .B(B), .DX_SWdata(DX_SWdata), .DX_RD(DX_RD), .ALUctr(ALUctr),
      .DX_RegWrite(DX_RegWrite), .DX_MemRead(DX_MemRead), .DX_MemWrite(DX_MemWrite),
      .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sw;
      logic [4:0]  rd;
      logic [2:0]  alu;
      logic        rw;
      logic        mr;
      logic        mw;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] sw, logic [4:0] rd,
                               logic [2:0] alu, logic rw, logic mr, logic mw);
      exp_t e;
      e.a = a; e.b = b; e.sw = sw; e.rd = rd; e.alu = alu; e.rw = rw; e.mr = mr; e.mw = mw;
      return e;
   endfunction

   localparam exp_t BUBBLE = '0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic compare_out(string tag, exp_t e);
      check({tag, ".A"},        A,                  e.a);
      check({tag, ".B"},        B,                  e.b);
      check({tag, ".SWdata"},   DX_SWdata,          e.sw);
      check({tag, ".RD"},       32'(DX_RD),         32'(e.rd));
      check({tag, ".ALUctr"},   32'(ALUctr),        32'(e.alu));
      check({tag, ".RegWrite"}, 32'(DX_RegWrite),   32'(e.rw));
      check({tag, ".MemRead"},  32'(DX_MemRead),    32'(e.mr));
      check({tag, ".MemWrite"}, 32'(DX_MemWrite),   32'(e.mw));
   endtask

   // Drive at the negedge, check stall before the posedge, check DX outputs at the following negedge.
   task automatic step(string tag, logic [31:0] ir, logic we, logic [4:0] rd, logic [31:0] data,
                       logic exp_stall, exp_t e);
      exp_t got;
      FD_IR       = ir;
      MW_RegWrite = we;
      MW_RD       = rd;
      MW_data     = data;
      exp_q.push_back(e);
      #1;
      check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s.queue observed=empty expected=entry", tag);
      end else begin
         got = exp_q.pop_front();
         compare_out(tag, got);
      end
   endtask

   task automatic wr(logic [4:0] rd, logic [31:0] data);
      step("wr", 32'h0000_0000, 1'b1, rd, data, 1'b0, BUBBLE);
   endtask

   initial begin
      rst         = 1'b1;
      FD_IR       = 32'h0;
      MW_RegWrite = 1'b0;
      MW_RD       = 5'd0;
      MW_data     = 32'h0;
      #1;
      compare_out("reset0", BUBBLE);
      check("reset0.stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      wr(5'd5, 32'h0000_1234);
      step("read_r5", 32'h00A0_3820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h1234, 32'h0, 32'h0, 5'd7, 3'd0, 1'b1, 1'b0, 1'b0));
      wr(5'd1, 32'd7);
      wr(5'd2, 32'd3);
      step("add", 32'h0022_1820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'd7, 32'd3, 32'd3, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0));
      step("sub", 32'h0022_1822, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'd7, 32'd3, 32'd3, 5'd3, 3'd1, 1'b1, 1'b0, 1'b0));
      step("slt", 32'h0022_182A, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'd7, 32'd3, 32'd3, 5'd3, 3'd2, 1'b1, 1'b0, 1'b0));
      step("bypass", 32'h0022_1820, 1'b1, 5'd2, 32'h0000_ABCD, 1'b0,
           mk(32'd7, 32'hABCD, 32'hABCD, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0));
      step("after_bypass", 32'h0022_1820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'd7, 32'hABCD, 32'hABCD, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0));
      step("r0_write", 32'h0000_1820, 1'b1, 5'd0, 32'h55, 1'b0,
           mk(32'h0, 32'h0, 32'h0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0));
      step("r0_read", 32'h0000_1820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h0, 32'h0, 32'h0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0));
      wr(5'd1, 32'h0000_0100);
      wr(5'd4, 32'hDEAD_BEEF);
      step("lw_neg", 32'h8C24_FFF8, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h100, 32'hFFFF_FFF8, 32'hDEAD_BEEF, 5'd4, 3'd0, 1'b1, 1'b1, 1'b0));
`ifdef LOAD_USE_STALL_EN
      step("lu_bubble", 32'h0082_2820, 1'b0, 5'd0, 32'h0, 1'b1, BUBBLE);
      step("lu_issue", 32'h0082_2820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'hDEAD_BEEF, 32'hABCD, 32'hABCD, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0));
`else
      step("lu_nostall", 32'h0082_2820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'hDEAD_BEEF, 32'hABCD, 32'hABCD, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0));
`endif
      step("sw", 32'hAC24_0004, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h100, 32'h4, 32'hDEAD_BEEF, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1));
      step("addi", 32'h2026_FFFF, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h100, 32'hFFFF_FFFF, 32'h0, 5'd6, 3'd0, 1'b1, 1'b0, 1'b0));
      step("bad_op", 32'hFC00_0000, 1'b0, 5'd0, 32'h0, 1'b0, BUBBLE);
      step("zero_word", 32'h0000_0000, 1'b0, 5'd0, 32'h0, 1'b0, BUBBLE);
      step("bad_funct", 32'h0022_1821, 1'b0, 5'd0, 32'h0, 1'b0, BUBBLE);
      step("lw_r0", 32'h8C20_0000, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h100, 32'h0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0));
      step("use_r0", 32'h0002_2820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h0, 32'hABCD, 32'hABCD, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0));
      step("lw_r4", 32'h8C24_0000, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h100, 32'h0, 32'hDEAD_BEEF, 5'd4, 3'd0, 1'b1, 1'b1, 1'b0));
`ifdef LOAD_USE_STALL_EN
      step("sw_rt_bubble", 32'hAC24_0004, 1'b0, 5'd0, 32'h0, 1'b1, BUBBLE);
`endif
      step("sw_rt", 32'hAC24_0004, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h100, 32'h4, 32'hDEAD_BEEF, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1));
      step("lw_r4b", 32'h8C24_0000, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h100, 32'h0, 32'hDEAD_BEEF, 5'd4, 3'd0, 1'b1, 1'b1, 1'b0));
      step("addi_rt_dst", 32'h20C4_0001, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h0, 32'h1, 32'hDEAD_BEEF, 5'd4, 3'd0, 1'b1, 1'b0, 1'b0));

      // Mid-stream reset with a write-back in flight.
      FD_IR       = 32'h0022_1820;
      MW_RegWrite = 1'b1;
      MW_RD       = 5'd8;
      MW_data     = 32'h77;
      rst         = 1'b1;
      #1;
      compare_out("rst_async", BUBBLE);
      check("rst_async.stall", 32'(stall), 32'd0);
      @(posedge clk);
      @(negedge clk);
      compare_out("rst_hold", BUBBLE);
      rst = 1'b0;
      step("post_rst", 32'h0105_4820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h0, 32'h0, 32'h0, 5'd9, 3'd0, 1'b1, 1'b0, 1'b0));
      wr(5'd5, 32'h0000_1234);
      step("reread_r5", 32'h00A0_3820, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(32'h1234, 32'h0, 32'h0, 5'd7, 3'd0, 1'b1, 1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage of the 5-stage MIPS pipeline.
- Decodes the fetched instruction, reads the 32x32 register file, sign-extends immediates and selects operands.
- Drives registered A, B, DX_RD, ALUctr and the memory/write-back controls into the execution stage.
- Hosts the register file write port used by write-back.

Parameters:
DATA_W, 32, datapath and register width.
RF_CLEAR, 1, 1 = register file cleared to 0 on rst; 0 = contents unchanged on rst.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
FD_IR  input  32  instruction from fetch stage.
MW_RegWrite  input  1  write-back enable.
MW_RD  input  5  write-back destination register.
MW_data  input  DATA_W  write-back data.
A  output  DATA_W  registered rs operand.
B  output  DATA_W  registered second operand: rt value or sign-extended immediate.
DX_SWdata  output  DATA_W  registered rt value, used as store data for sw.
DX_RD  output  5  registered destination register; 0 when none.
ALUctr  output  3  registered ALU op: 0 add, 1 sub, 2 slt.
DX_RegWrite  output  1  registered write-back enable.
DX_MemRead  output  1  registered load flag.
DX_MemWrite  output  1  registered store flag.
stall  output  1  combinational; hold fetch (LOAD_USE_STALL_EN only, else constant 0).

Behaviour:
- Field split: op=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], funct=IR[5:0], imm=IR[15:0].
- op 0x00, funct 0x20 (add) / 0x22 (sub) / 0x2A (slt): ALUctr=0/1/2, B=R[rt], DX_RD=rd, RegWrite=1.
- op 0x08 (addi): ALUctr=0, B=sext(imm), DX_RD=rt, RegWrite=1.
- op 0x23 (lw): ALUctr=0, B=sext(imm), DX_RD=rt, RegWrite=1, MemRead=1.
- op 0x2B (sw): ALUctr=0, B=sext(imm), DX_RD=0, MemWrite=1, DX_SWdata=R[rt].
- Any other op/funct, including 0x00000000: bubble. All DX outputs 0 (A=B=0, DX_RD=0, ALUctr=0, all flags 0).
- A=R[rs] for all valid instructions.
- sext: imm[15] replicated to DATA_W bits.
- Latency: one cycle. Outputs reflect FD_IR sampled at the previous posedge.
- Register file write: on posedge when MW_RegWrite=1 and MW_RD!=0. Register 0 reads 0 always; writes to it are ignored.
- Write-before-read bypass: if MW_RegWrite=1, MW_RD!=0 and MW_RD equals rs or rt in the same cycle, the read returns MW_data.
- A rt-based B is bypassed the same way; DX_SWdata likewise.
- rst asserted: all outputs go to 0 immediately, asynchronously. If RF_CLEAR=1, all registers are also cleared to 0.
- rst applied mid-operation: any in-flight write that cycle is discarded.
- After rst deasserts, the first posedge decodes FD_IR normally.
- No other state; no internal FSM beyond the pipeline register and register file.

Optional Feature:
LOAD_USE_STALL_EN
- Defined:
  - stall=1 when DX_MemRead=1, DX_RD!=0, and DX_RD equals rs, or equals rt for R-type/sw.
  - While stall=1, the next posedge loads a bubble into all DX outputs; fetch holds FD_IR.
  - The following cycle sees DX_MemRead=0, so stall drops and the instruction issues normally.
  - The penalty is exactly one bubble per load-use pair.
  - rst clears stall via DX_MemRead=0.
- Undefined: stall tied to 0; no bubble insertion. Software must schedule around load-use hazards.

Test Plan:
- Reset: rst=1 mid-stream -> all outputs 0 immediately. Then write R5=0x1234 and read it -> 0x1234. With RF_CLEAR=1, R6 reads 0.
- Write R1=7 and R2=3, then issue add $3,$1,$2 (0x00221820) -> next cycle A=7, B=3, ALUctr=0, DX_RD=3, DX_RegWrite=1. sub and slt give ALUctr=1 and 2.
- lw $4,-8($1) (0x8C24FFF8) with R1=0x100 -> A=0x100, B=0xFFFFFFF8, DX_RD=4, MemRead=1. sw $4,4($1) -> B=4, DX_RD=0, MemWrite=1, DX_SWdata=R4.
- Bypass: MW_RegWrite=1, MW_RD=2, MW_data=0xABCD in the same cycle as add $3,$1,$2 -> B=0xABCD. Write to R0 -> subsequent read of R0 = 0.
- Unknown opcode 0xFC000000 and all-zero word -> bubble: all DX outputs 0.
- LOAD_USE_STALL_EN: lw $4,0($1) followed by add $5,$4,$2 -> stall=1 for one cycle, one bubble, then add issues with DX_RD=5. Without the macro -> stall=0 and no bubble.
